serial_subtractor_ctrl: RTL and testbench
=========================================

// Module: serial_subtractor_ctrl
// PURPOSE
//   Bit-serial N-bit subtract controller built around one full_subtractor_case cell.
//   Latches two WIDTH-bit operands, feeds the cell one bit per clock (LSB first) and
//   carries the borrow between bits in a flop. Presents the WIDTH-bit difference and final borrow.
//   Area-lean alternative to a ripple array: one cell reused WIDTH times under FSM control.
// PARAMETERS
//   WIDTH    8    operand/result width in bits (legal range 2..32)
// PORTS
//   clk      in   1      single clock, all state updates on rising edge
//   rst      in   1      synchronous reset, active-high
//   start    in   1      request; sampled only in IDLE
//   A        in   WIDTH  minuend, sampled on the edge that accepts start
//   B        in   WIDTH  subtrahend, sampled with A
//   Bin      in   1      borrow-in, sampled with A
//   busy     out  1      high while bits are being processed (SHIFT state)
//   done     out  1      one-cycle completion pulse
//   Diff     out  WIDTH  registered result; held stable until next completion
//   Borr     out  1      registered final borrow-out; held with Diff
// BEHAVIOUR
//   - Clocking: one clock (clk). Reset is synchronous, active-high (rst).
//   - Reset: state=IDLE; busy=0, done=0, Diff=0, Borr=0; shift regs, borrow flop, counter cleared.
//   - Reset mid-operation: aborts the operation. Same values as reset on the next edge.
//     Partial result is discarded. rst has priority over start.
//   - FSM: IDLE -> SHIFT on start=1. SHIFT -> DONE after WIDTH bit-steps. DONE -> IDLE unconditionally.
//   - IDLE + start=1, edge k: load a_sr<=A, b_sr<=B, brw<=Bin, cnt<=0; busy=1 from edge k.
//   - SHIFT, edges k+1..k+WIDTH: the cell sees (a_sr[0], b_sr[0], brw).
//     Cell Diff shifts into r_sr MSB; a_sr and b_sr shift right; brw<=cell Borr; cnt++.
//   - At edge k+WIDTH (cnt==WIDTH-1): Diff<=final r_sr, Borr<=final cell Borr.
//     done<=1, busy<=0, state<=DONE.
//   - Latency: done rises exactly WIDTH edges after the accepting edge.
//     busy is high for exactly WIDTH cycles. Throughput: one op per WIDTH+2 cycles.
//   - DONE: done high for exactly that one cycle. Next edge returns to IDLE with done=0.
//   - start while busy or in DONE is ignored. It is not queued.
//     The operation in flight is unaffected; operand inputs may change freely.
//   - Arithmetic (unsigned): Diff = (A - B - Bin) mod 2^WIDTH.
//     Borr = 1 iff A < B + Bin.
//   - Diff/Borr change only on the completion edge or on reset. They never show partial values.
//   - Counter width: $clog2(WIDTH). Unused encodings of state go to IDLE (safe default).
// STRUCTURE
//   - Shared header serial_sub_pkg.vh holds:
//     state encodings S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2, and DEFAULT_WIDTH=8.
//   - One sub-module: a single instance of full_subtractor_case (ports A,B,Bin,Diff,Borr).
//     It is the only arithmetic in the block.
//   - Registers in this block: FSM state, cnt, a_sr, b_sr, r_sr, brw, and the Diff/Borr/done output regs.
// TESTING (WIDTH=8 unless noted; bench checks done timing every op)
//   1. A=8'h0F, B=8'h05, Bin=0, start pulse -> done 8 edges later; Diff=8'h0A, Borr=0; busy high 8 cycles.
//   2. A=8'h05, B=8'h0F, Bin=0 -> Diff=8'hF6, Borr=1.
//      Then A=8'h00, B=8'h00, Bin=1 -> Diff=8'hFF, Borr=1.
//   3. A=8'hFF, B=8'hFF, Bin=0. Re-pulse start with A=8'h01 on busy cycle 3, and again in DONE cycle.
//      -> single done, Diff=8'h00, Borr=0; second start is not executed.
//   4. rst=1 on busy cycle 4 -> next edge busy=0, done=0, Diff=0, Borr=0, no done pulse.
//      A new start then yields a correct result for A=8'h80, B=8'h01, Bin=0 -> Diff=8'h7F, Borr=0.
//   5. Back-to-back: start held high continuously.
//      -> ops accepted every WIDTH+2 cycles; Diff/Borr stable between done pulses.
//   6. WIDTH=4 build: exhaustive 16x16x2 operand sweep.
//      -> Diff/Borr match the (A-B-Bin) model for all 512 cases.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encodings and defaults for the serial subtractor
package serial_sub_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor_case.sv
// rtl/full_subtractor_case.sv - one-bit full subtractor written as a truth table
module full_subtractor_case (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic Diff,
    output logic Borr
);

    always_comb begin
        Diff = 1'b0;
        Borr = 1'b0;
        case ({A, B, Bin})
            3'b000: begin Diff = 1'b0; Borr = 1'b0; end
            3'b001: begin Diff = 1'b1; Borr = 1'b1; end
            3'b010: begin Diff = 1'b1; Borr = 1'b1; end
            3'b011: begin Diff = 1'b0; Borr = 1'b1; end
            3'b100: begin Diff = 1'b1; Borr = 1'b0; end
            3'b101: begin Diff = 1'b0; Borr = 1'b0; end
            3'b110: begin Diff = 1'b0; Borr = 1'b0; end
            3'b111: begin Diff = 1'b1; Borr = 1'b1; end
            default: begin Diff = 1'b0; Borr = 1'b0; end
        endcase
    end

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// rtl/serial_subtractor_ctrl.sv - bit-serial WIDTH-bit subtractor reusing one full-subtractor cell
module serial_subtractor_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
    output logic             Borr
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [WIDTH-2:0] r_sr;
    logic             brw;
    logic             load, step, last;
    logic             cell_diff, cell_borr;
    logic [WIDTH-1:0] r_next;

    full_subtractor_case u_cell (
        .A    (a_sr[0]),
        .B    (b_sr[0]),
        .Bin  (brw),
        .Diff (cell_diff),
        .Borr (cell_borr)
    );

    // r_sr only keeps the WIDTH-1 earlier bits; the current cell bit completes the word
    assign r_next = {cell_diff, r_sr};
    assign busy   = (state == S_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                step = 1'b1;
                if (cnt == CNT_LAST) begin
                    last      = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            a_sr <= '0;
            b_sr <= '0;
            r_sr <= '0;
            brw  <= 1'b0;
            done <= 1'b0;
            Diff <= '0;
            Borr <= 1'b0;
        end else begin
            done <= last;
            if (load) begin
                a_sr <= A;
                b_sr <= B;
                brw  <= Bin;
                cnt  <= '0;
            end
            if (step) begin
                a_sr <= a_sr >> 1;
                b_sr <= b_sr >> 1;
                r_sr <= r_next[WIDTH-1:1];
                brw  <= cell_borr;
                cnt  <= cnt + CW'(1);
            end
            // outputs move only here so partial results never appear
            if (last) begin
                Diff <= r_next;
                Borr <= cell_borr;
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb/tb_serial_subtractor_ctrl.sv - directed-vector bench for serial_subtractor_ctrl (WIDTH 8 and 4)
module tb_serial_subtractor_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, bin8, busy8, done8, borr8;
    logic [7:0] a8, b8, diff8;
    logic       start4, bin4, busy4, done4, borr4;
    logic [3:0] a4, b4, diff4;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
        .clk (clk), .rst (rst), .start (start8),
        .A (a8), .B (b8), .Bin (bin8),
        .busy (busy8), .done (done8), .Diff (diff8), .Borr (borr8)
    );

    serial_subtractor_ctrl #(.WIDTH(4)) dut4 (
        .clk (clk), .rst (rst), .start (start4),
        .A (a4), .B (b4), .Bin (bin4),
        .busy (busy4), .done (done4), .Diff (diff4), .Borr (borr4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bin,
                       input logic [7:0] ed, input logic eb,
                       input int inj_busy, input bit inj_done, input int rst_at);
        int n;
        int bc;
        int seen;
        @(negedge clk);
        a8 = a; b8 = b; bin8 = bin; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        n  = 0;
        bc = 0;
        while (!done8 && n < 20) begin
            if (n == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check({tag, "_rst_busy"}, busy8, 0);
                check({tag, "_rst_done"}, done8, 0);
                check({tag, "_rst_diff"}, diff8, 0);
                check({tag, "_rst_borr"}, borr8, 0);
                seen = 0;
                repeat (12) begin
                    if (done8 || busy8) seen++;
                    @(negedge clk);
                end
                check({tag, "_rst_quiet"}, seen, 0);
                return;
            end
            if (busy8) bc++;
            if (n == inj_busy) begin
                start8 = 1'b1;
                a8     = 8'h01;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start8 = 1'b0;
        check({tag, "_latency"}, n, 8);
        check({tag, "_busy_cycles"}, bc, 8);
        check({tag, "_diff"}, diff8, ed);
        check({tag, "_borr"}, borr8, eb);
        if (inj_done) begin
            start8 = 1'b1;
            a8     = 8'h01;
        end
        @(negedge clk);
        start8 = 1'b0;
        check({tag, "_done_pulse"}, done8, 0);
        check({tag, "_idle_busy"}, busy8, 0);
        check({tag, "_diff_held"}, diff8, ed);
        @(negedge clk);
        check({tag, "_no_restart"}, busy8, 0);
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bin);
        int n;
        logic [4:0] exp;
        exp = {1'b0, a} - {1'b0, b} - {4'b0, bin};
        @(negedge clk);
        a4 = a; b4 = b; bin4 = bin; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("w4_latency", n, 4);
        check("w4_diff", diff4, exp[3:0]);
        check("w4_borr", borr4, exp[4]);
    endtask

    initial begin
        int pulses;
        int last_t;
        int unstable;
        logic [7:0] held;

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", busy8, 0);
        check("reset_done", done8, 0);
        check("reset_diff", diff8, 0);
        check("reset_borr", borr8, 0);
        check("reset_busy4", busy4, 0);

        op8("t1",  8'h0F, 8'h05, 1'b0, 8'h0A, 1'b0, -1, 1'b0, -1);
        op8("t2a", 8'h05, 8'h0F, 1'b0, 8'hF6, 1'b1, -1, 1'b0, -1);
        op8("t2b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, -1, 1'b0, -1);
        op8("t4",  8'h80, 8'h01, 1'b0, 8'h00, 1'b0, -1, 1'b0, 3);
        op8("t4b", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, -1, 1'b0, -1);
        op8("t3",  8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 2, 1'b1, -1);

        // start held high: operands change after the first completion
        @(negedge clk);
        a8 = 8'h3C; b8 = 8'h0F; bin8 = 1'b0; start8 = 1'b1;
        pulses   = 0;
        last_t   = 0;
        unstable = 0;
        held     = 8'h00;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (done8) begin
                if (pulses == 0) begin
                    check("t5_diff0", diff8, 8'h2D);
                    check("t5_borr0", borr8, 0);
                end else begin
                    check("t5_diff", diff8, 8'hF0);
                    check("t5_borr", borr8, 1);
                    check("t5_interval", t - last_t, 10);
                end
                last_t = t;
                pulses++;
                held = diff8;
                a8 = 8'h10;
                b8 = 8'h20;
            end else if (pulses > 0 && diff8 !== held) begin
                unstable++;
            end
        end
        start8 = 1'b0;
        check("t5_pulses", pulses, 4);
        check("t5_stable", unstable, 0);
        repeat (12) @(negedge clk);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    op4(4'(a), 4'(b), 1'(c));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
